// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: deserialises 3-byte movement packets and tracks a
// saturated cursor position plus button levels on a fixed-size canvas.
module ps2_mouse_tracker #(
  parameter int CANVAS_WIDTH   = 360,
  parameter int CANVAS_HEIGHT  = 720,
  parameter int INVERT_Y       = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             clk_ps2_raw,
  input  logic                             ps2_data,
  output logic [$clog2(CANVAS_WIDTH)-1:0]  mouse_x,
  output logic [$clog2(CANVAS_HEIGHT)-1:0] mouse_y,
  output logic                             btn_left,
  output logic                             btn_right,
  output logic                             btn_middle,
  output logic                             click,
  output logic                             pkt_valid,
  output logic                             err_frame
);
  localparam int XW   = $clog2(CANVAS_WIDTH);
  localparam int YW   = $clog2(CANVAS_HEIGHT);
  localparam int MW   = (XW > YW) ? XW : YW;
  localparam int SW   = ((MW > 9) ? MW : 9) + 2;
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNTW-1:0]      TIMEOUT_CNT = CNTW'(TIMEOUT_CYCLES);
  localparam logic signed [SW-1:0] ZERO_S      = '0;
  localparam logic signed [SW-1:0] X_MAX_S     = SW'(CANVAS_WIDTH - 1);
  localparam logic signed [SW-1:0] Y_MAX_S     = SW'(CANVAS_HEIGHT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;

  function automatic logic odd_parity(input logic [7:0] d, input logic p);
    odd_parity = ^{d, p};
  endfunction

  function automatic logic signed [SW-1:0] sat(input logic signed [SW-1:0] v,
                                               input logic signed [SW-1:0] hi);
    if (v < ZERO_S) sat = ZERO_S;
    else if (v > hi) sat = hi;
    else sat = v;
  endfunction

  logic [1:0]      clk_sync_q, data_sync_q;
  logic            clk_prev_q;
  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [6:0]      status_q, status_d;   // {y_ovf, x_ovf, y_sign, x_sign, mid, right, left}
  logic [7:0]      dx_q, dx_d;
  logic [CNTW-1:0] idle_cnt_q, idle_cnt_d;
  logic [XW-1:0]   mouse_x_q, mouse_x_d;
  logic [YW-1:0]   mouse_y_q, mouse_y_d;
  logic            btn_left_q, btn_left_d, btn_right_q, btn_right_d, btn_middle_q, btn_middle_d;
  logic            click_q, click_d, pkt_valid_q, pkt_valid_d, err_frame_q, err_frame_d;

  logic            fall_s, timeout_s, bit_s;
  logic [8:0]      dx9_s, dy9_s;
  logic signed [SW-1:0] x_ext_s, y_ext_s, dx_ext_s, dy_ext_s, x_sum_s, y_sum_s;

  assign fall_s    = clk_prev_q & ~clk_sync_q[1];
  assign bit_s     = data_sync_q[1];
  assign timeout_s = (idle_cnt_q == TIMEOUT_CNT) && ((state_q != ST_IDLE) || (byte_idx_q != 2'd0));

  // Byte 2 (dy) is still in the shift register when its stop bit arrives.
  assign dx9_s    = status_q[5] ? 9'd0 : {status_q[3], dx_q};
  assign dy9_s    = status_q[6] ? 9'd0 : {status_q[4], shift_q};
  assign x_ext_s  = $signed({{(SW-XW){1'b0}}, mouse_x_q});
  assign y_ext_s  = $signed({{(SW-YW){1'b0}}, mouse_y_q});
  assign dx_ext_s = $signed({{(SW-9){dx9_s[8]}}, dx9_s});
  assign dy_ext_s = $signed({{(SW-9){dy9_s[8]}}, dy9_s});
  assign x_sum_s  = x_ext_s + dx_ext_s;
  assign y_sum_s  = (INVERT_Y != 0) ? (y_ext_s - dy_ext_s) : (y_ext_s + dy_ext_s);

  // Frame deserialiser, packet assembly, idle timeout and output update.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_idx_d   = byte_idx_q;
    status_d     = status_q;
    dx_d         = dx_q;
    idle_cnt_d   = idle_cnt_q;
    mouse_x_d    = mouse_x_q;
    mouse_y_d    = mouse_y_q;
    btn_left_d   = btn_left_q;
    btn_right_d  = btn_right_q;
    btn_middle_d = btn_middle_q;
    click_d      = 1'b0;
    pkt_valid_d  = 1'b0;
    err_frame_d  = 1'b0;
    if (fall_s) begin
      idle_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = 3'd0;
          if (!bit_s) state_d = ST_DATA;
          else state_d = ST_IDLE;
        end
        ST_DATA: begin
          shift_d = {bit_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
        ST_PARITY: begin
          par_d   = bit_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!odd_parity(shift_q, par_q) || !bit_s) begin
            err_frame_d = 1'b1;
            byte_idx_d  = 2'd0;
          end else begin
            case (byte_idx_q)
              2'd0: begin
                if (shift_q[3]) begin
                  status_d   = {shift_q[7:4], shift_q[2:0]};
                  byte_idx_d = 2'd1;
                end else begin
                  err_frame_d = 1'b1;
                  byte_idx_d  = 2'd0;
                end
              end
              2'd1: begin
                dx_d       = shift_q;
                byte_idx_d = 2'd2;
              end
              2'd2: begin
                byte_idx_d   = 2'd0;
                mouse_x_d    = XW'(sat(x_sum_s, X_MAX_S));
                mouse_y_d    = YW'(sat(y_sum_s, Y_MAX_S));
                btn_left_d   = status_q[0];
                btn_right_d  = status_q[1];
                btn_middle_d = status_q[2];
                click_d      = status_q[0] & ~btn_left_q;
                pkt_valid_d  = 1'b1;
              end
              default: byte_idx_d = 2'd0;
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_s) begin
      state_d    = ST_IDLE;
      byte_idx_d = 2'd0;
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TIMEOUT_CNT) begin
      idle_cnt_d = idle_cnt_q + CNTW'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  // State and output registers; synchronisers idle high like the PS/2 bus.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      clk_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      par_q        <= 1'b0;
      byte_idx_q   <= 2'd0;
      status_q     <= 7'd0;
      dx_q         <= 8'd0;
      idle_cnt_q   <= '0;
      mouse_x_q    <= XW'(CANVAS_WIDTH / 2);
      mouse_y_q    <= YW'(CANVAS_HEIGHT / 2);
      btn_left_q   <= 1'b0;
      btn_right_q  <= 1'b0;
      btn_middle_q <= 1'b0;
      click_q      <= 1'b0;
      pkt_valid_q  <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], clk_ps2_raw};
      data_sync_q  <= {data_sync_q[0], ps2_data};
      clk_prev_q   <= clk_sync_q[1];
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      byte_idx_q   <= byte_idx_d;
      status_q     <= status_d;
      dx_q         <= dx_d;
      idle_cnt_q   <= idle_cnt_d;
      mouse_x_q    <= mouse_x_d;
      mouse_y_q    <= mouse_y_d;
      btn_left_q   <= btn_left_d;
      btn_right_q  <= btn_right_d;
      btn_middle_q <= btn_middle_d;
      click_q      <= click_d;
      pkt_valid_q  <= pkt_valid_d;
      err_frame_q  <= err_frame_d;
    end
  end

  assign mouse_x    = mouse_x_q;
  assign mouse_y    = mouse_y_q;
  assign btn_left   = btn_left_q;
  assign btn_right  = btn_right_q;
  assign btn_middle = btn_middle_q;
  assign click      = click_q;
  assign pkt_valid  = pkt_valid_q;
  assign err_frame  = err_frame_q;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: drives PS/2 frames and checks position,
// buttons and pulse counts against hand-computed values.
module tb_ps2_mouse_tracker;
  localparam int TO   = 500;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [8:0] mouse_x;
  logic [9:0] mouse_y;
  logic       btn_left, btn_right, btn_middle, click, pkt_valid, err_frame;

  int n_checks = 0;
  int n_fail   = 0;
  int pv_cnt = 0, ck_cnt = 0, er_cnt = 0;
  int x_at_pv = 0, y_at_pv = 0;
  int pv0, ck0, er0;

  ps2_mouse_tracker #(.CANVAS_WIDTH(360), .CANVAS_HEIGHT(720), .INVERT_Y(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk), .rst_in(rst_n), .clk_ps2_raw(ps2_clk), .ps2_data(ps2_dat),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .btn_left(btn_left), .btn_right(btn_right),
    .btn_middle(btn_middle), .click(click), .pkt_valid(pkt_valid), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  // Pulse counters and the position seen while pkt_valid is high.
  always @(negedge clk) begin
    if (pkt_valid) begin
      pv_cnt  = pv_cnt + 1;
      x_at_pv = mouse_x;
      y_at_pv = mouse_y;
    end
    if (click) ck_cnt = ck_cnt + 1;
    if (err_frame) er_cnt = er_cnt + 1;
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(~bad_stop);
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b0, 1'b0);
    send_frame(b1, 1'b0, 1'b0);
    send_frame(b2, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  task automatic snap();
    pv0 = pv_cnt; ck0 = ck_cnt; er0 = er_cnt;
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (mouse_x !== 9'd180) begin n_fail++; $display("FAIL reset_x: got %0d expected 180", mouse_x); end
    n_checks++; if (mouse_y !== 10'd360) begin n_fail++; $display("FAIL reset_y: got %0d expected 360", mouse_y); end
    n_checks++; if ({btn_left, btn_right, btn_middle} !== 3'b000) begin n_fail++; $display("FAIL reset_btn: got %b expected 000", {btn_left, btn_right, btn_middle}); end
    n_checks++; if ({click, pkt_valid, err_frame} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {click, pkt_valid, err_frame}); end
  endtask

  task automatic test_packet();
    snap();
    send_pkt(8'h09, 8'h05, 8'h03);
    n_checks++; if (mouse_x !== 9'd185) begin n_fail++; $display("FAIL pkt_x: got %0d expected 185", mouse_x); end
    n_checks++; if (mouse_y !== 10'd357) begin n_fail++; $display("FAIL pkt_y: got %0d expected 357", mouse_y); end
    n_checks++; if (btn_left !== 1'b1) begin n_fail++; $display("FAIL pkt_left: got %b expected 1", btn_left); end
    n_checks++; if (pv_cnt - pv0 !== 1) begin n_fail++; $display("FAIL pkt_valid_cycles: got %0d expected 1", pv_cnt - pv0); end
    n_checks++; if (ck_cnt - ck0 !== 1) begin n_fail++; $display("FAIL pkt_click_cycles: got %0d expected 1", ck_cnt - ck0); end
    n_checks++; if (er_cnt - er0 !== 0) begin n_fail++; $display("FAIL pkt_err: got %0d expected 0", er_cnt - er0); end
    n_checks++; if (x_at_pv !== 185 || y_at_pv !== 357) begin n_fail++; $display("FAIL pkt_pos_at_valid: got %0d,%0d expected 185,357", x_at_pv, y_at_pv); end
  endtask

  task automatic test_saturate_low();
    snap();
    send_pkt(8'h19, 8'h4C, 8'h00);
    n_checks++; if (mouse_x !== 9'd5) begin n_fail++; $display("FAIL neg_x: got %0d expected 5", mouse_x); end
    n_checks++; if (ck_cnt - ck0 !== 0) begin n_fail++; $display("FAIL held_no_click: got %0d expected 0", ck_cnt - ck0); end
    send_pkt(8'h18, 8'hF6, 8'h00);
    n_checks++; if (mouse_x !== 9'd0) begin n_fail++; $display("FAIL sat_x_low: got %0d expected 0", mouse_x); end
    n_checks++; if (mouse_y !== 10'd357) begin n_fail++; $display("FAIL sat_x_low_y: got %0d expected 357", mouse_y); end
    n_checks++; if (btn_left !== 1'b0) begin n_fail++; $display("FAIL sat_x_low_left: got %b expected 0", btn_left); end
  endtask

  task automatic test_saturate_high();
    send_pkt(8'h08, 8'hFF, 8'h00);
    n_checks++; if (mouse_x !== 9'd255) begin n_fail++; $display("FAIL x_plus255: got %0d expected 255", mouse_x); end
    send_pkt(8'h28, 8'hFF, 8'h00);
    n_checks++; if (mouse_x !== 9'd359) begin n_fail++; $display("FAIL sat_x_high: got %0d expected 359", mouse_x); end
    n_checks++; if (mouse_y !== 10'd613) begin n_fail++; $display("FAIL y_minus256: got %0d expected 613", mouse_y); end
    send_pkt(8'h28, 8'h00, 8'h00);
    n_checks++; if (mouse_y !== 10'd719) begin n_fail++; $display("FAIL sat_y_high: got %0d expected 719", mouse_y); end
    for (int i = 0; i < 3; i++) send_pkt(8'h08, 8'h00, 8'hFF);
    n_checks++; if (mouse_y !== 10'd0) begin n_fail++; $display("FAIL sat_y_low: got %0d expected 0", mouse_y); end
    n_checks++; if (mouse_x !== 9'd359) begin n_fail++; $display("FAIL sat_y_low_x: got %0d expected 359", mouse_x); end
  endtask

  task automatic test_overflow_buttons();
    snap();
    send_pkt(8'hCE, 8'h12, 8'h34);
    n_checks++; if (mouse_x !== 9'd359 || mouse_y !== 10'd0) begin n_fail++; $display("FAIL ovf_pos: got %0d,%0d expected 359,0", mouse_x, mouse_y); end
    n_checks++; if ({btn_left, btn_right, btn_middle} !== 3'b011) begin n_fail++; $display("FAIL ovf_btn: got %b expected 011", {btn_left, btn_right, btn_middle}); end
    n_checks++; if (pv_cnt - pv0 !== 1) begin n_fail++; $display("FAIL ovf_valid: got %0d expected 1", pv_cnt - pv0); end
  endtask

  task automatic test_frame_errors();
    snap();
    send_frame(8'h08, 1'b0, 1'b0);
    send_frame(8'h10, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++; if (er_cnt - er0 !== 1) begin n_fail++; $display("FAIL parity_err: got %0d expected 1", er_cnt - er0); end
    n_checks++; if (pv_cnt - pv0 !== 0) begin n_fail++; $display("FAIL parity_no_valid: got %0d expected 0", pv_cnt - pv0); end
    n_checks++; if (mouse_x !== 9'd359 || btn_right !== 1'b1) begin n_fail++; $display("FAIL parity_unchanged: got %0d,%b expected 359,1", mouse_x, btn_right); end
    send_pkt(8'h18, 8'h0A, 8'h00);
    n_checks++; if (mouse_x !== 9'd113 || btn_right !== 1'b0) begin n_fail++; $display("FAIL after_parity: got %0d,%b expected 113,0", mouse_x, btn_right); end
    snap();
    send_frame(8'h08, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    n_checks++; if (er_cnt - er0 !== 1) begin n_fail++; $display("FAIL stop_err: got %0d expected 1", er_cnt - er0); end
    send_pkt(8'h08, 8'h01, 8'h00);
    n_checks++; if (mouse_x !== 9'd114) begin n_fail++; $display("FAIL after_stop: got %0d expected 114", mouse_x); end
  endtask

  task automatic test_status_bit3();
    snap();
    send_frame(8'h01, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++; if (er_cnt - er0 !== 1) begin n_fail++; $display("FAIL bit3_err: got %0d expected 1", er_cnt - er0); end
    n_checks++; if (pv_cnt - pv0 !== 0) begin n_fail++; $display("FAIL bit3_no_valid: got %0d expected 0", pv_cnt - pv0); end
    send_pkt(8'h29, 8'h01, 8'hF0);
    n_checks++; if (mouse_x !== 9'd115 || mouse_y !== 10'd16) begin n_fail++; $display("FAIL bit3_next_pos: got %0d,%0d expected 115,16", mouse_x, mouse_y); end
    n_checks++; if (btn_left !== 1'b1 || ck_cnt - ck0 !== 1) begin n_fail++; $display("FAIL bit3_next_click: got %b,%0d expected 1,1", btn_left, ck_cnt - ck0); end
  endtask

  task automatic test_timeout();
    snap();
    send_frame(8'h08, 1'b0, 1'b0);
    repeat (TO + 1) @(negedge clk);
    send_pkt(8'h48, 8'h7F, 8'h02);
    n_checks++; if (mouse_x !== 9'd115 || mouse_y !== 10'd14) begin n_fail++; $display("FAIL timeout_pos: got %0d,%0d expected 115,14", mouse_x, mouse_y); end
    n_checks++; if (pv_cnt - pv0 !== 1) begin n_fail++; $display("FAIL timeout_valid: got %0d expected 1", pv_cnt - pv0); end
    n_checks++; if (er_cnt - er0 !== 0 || btn_left !== 1'b0) begin n_fail++; $display("FAIL timeout_err_btn: got %0d,%b expected 0,0", er_cnt - er0, btn_left); end
  endtask

  task automatic test_back_to_back();
    snap();
    send_frame(8'h08, 1'b0, 1'b0); send_frame(8'h02, 1'b0, 1'b0); send_frame(8'h00, 1'b0, 1'b0);
    send_frame(8'h08, 1'b0, 1'b0); send_frame(8'h03, 1'b0, 1'b0); send_frame(8'h00, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++; if (mouse_x !== 9'd120) begin n_fail++; $display("FAIL b2b_x: got %0d expected 120", mouse_x); end
    n_checks++; if (pv_cnt - pv0 !== 2) begin n_fail++; $display("FAIL b2b_valid: got %0d expected 2", pv_cnt - pv0); end
  endtask

  task automatic test_reset_mid_frame();
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (mouse_x !== 9'd180 || mouse_y !== 10'd360) begin n_fail++; $display("FAIL midrst_pos: got %0d,%0d expected 180,360", mouse_x, mouse_y); end
    n_checks++; if ({btn_left, btn_right, btn_middle, click, pkt_valid, err_frame} !== 6'd0) begin n_fail++; $display("FAIL midrst_flags: got %b expected 000000", {btn_left, btn_right, btn_middle, click, pkt_valid, err_frame}); end
    snap();
    send_pkt(8'h09, 8'h05, 8'h03);
    n_checks++; if (mouse_x !== 9'd185 || mouse_y !== 10'd357) begin n_fail++; $display("FAIL midrst_next: got %0d,%0d expected 185,357", mouse_x, mouse_y); end
    n_checks++; if (pv_cnt - pv0 !== 1 || er_cnt - er0 !== 0) begin n_fail++; $display("FAIL midrst_pulses: got %0d,%0d expected 1,0", pv_cnt - pv0, er_cnt - er0); end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_saturate_low();
    test_saturate_high();
    test_overflow_buttons();
    test_frame_errors();
    test_status_bit3();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
